// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC selection, imem request/ready handshake with
// redirect draining, and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  input  logic        PCSrcWB,
  input  logic [31:0] ResultWB,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PCF,
  output logic        ImemWaitF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD
);

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcplus8;
  logic        r_valid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_load;

  assign w_redirect = BranchTakenE | PCSrcWB;
  assign w_target   = BranchTakenE ? BranchTargetE : ResultWB;
  assign w_load     = (r_state == S_FETCH) & imem_ready & ~StallF & ~w_redirect;

  assign imem_req  = (r_state != S_RESET);
  assign imem_addr = r_pc;
  assign PCF       = r_pc;
  assign ImemWaitF = ((r_state == S_FETCH) & ~imem_ready) | (r_state == S_DRAIN) |
                     (r_state == S_RESET);
  assign InstrD    = r_instr;
  assign PCPlus8D  = r_pcplus8;
  assign ValidD    = r_valid;

  // S_DRAIN keeps the address stable until the outstanding fetch returns,
  // then jumps to the most recent redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_RESET;
      r_pc         <= RESET_PC;
      r_pending_pc <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_redirect) begin
            if (imem_ready) begin
              r_pc <= w_target;
            end else begin
              r_pending_pc <= w_target;
              r_state      <= S_DRAIN;
            end
          end else if (imem_ready && !StallF) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        S_DRAIN: begin
          if (w_redirect) r_pending_pc <= w_target;
          if (imem_ready) begin
            r_pc    <= w_redirect ? w_target : r_pending_pc;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_RESET;
      endcase
    end
  end

  // IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr   <= NOP_INSTR;
      r_pcplus8 <= 32'h0000_0000;
      r_valid   <= 1'b0;
    end else if (FlushD) begin
      r_instr   <= NOP_INSTR;
      r_pcplus8 <= 32'h0000_0000;
      r_valid   <= 1'b0;
    end else if (!StallD) begin
      if (w_load) begin
        r_instr   <= imem_rdata;
        r_pcplus8 <= r_pc + 32'd8;
        r_valid   <= 1'b1;
      end else begin
        r_instr   <= NOP_INSTR;
        r_pcplus8 <= 32'h0000_0000;
        r_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: spec-level model checked every cycle plus
// hand-computed literal expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk;
  logic        reset = 1'b0;
  logic        StallF = 0, StallD = 0, FlushD = 0;
  logic        BranchTakenE = 0, PCSrcWB = 0;
  logic [31:0] BranchTargetE = 0, ResultWB = 0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1;
  logic [31:0] PCF;
  logic        ImemWaitF;
  logic [31:0] InstrD;
  logic [31:0] PCPlus8D;
  logic        ValidD;
  logic        bad = 0;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .PCSrcWB(PCSrcWB), .ResultWB(ResultWB),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .PCF(PCF), .ImemWaitF(ImemWaitF),
    .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return bad ? 32'hDEAD_BEEF : 32'h1000_0000 + a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Behavioural model
  logic        m_live, m_drain, m_valid;
  logic [31:0] m_pc, m_pend, m_instr, m_pc8;
  wire         redir = BranchTakenE | PCSrcWB;
  wire  [31:0] tgt   = BranchTakenE ? BranchTargetE : ResultWB;
  wire         fetch_ok = m_live & ~m_drain & imem_ready & ~StallF & ~redir;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_live <= 0; m_drain <= 0; m_pc <= 0; m_pend <= 0;
      m_instr <= NOP; m_pc8 <= 0; m_valid <= 0;
    end else begin
      m_live <= 1;
      if (m_live && m_drain) begin
        if (imem_ready) begin
          m_pc <= redir ? tgt : m_pend;
          m_drain <= 0;
        end else if (redir) m_pend <= tgt;
      end else if (m_live) begin
        if (redir && imem_ready) m_pc <= tgt;
        else if (redir) begin
          m_pend <= tgt; m_drain <= 1;
        end else if (imem_ready && !StallF) m_pc <= m_pc + 4;
      end
      if (FlushD || (!StallD && !fetch_ok)) begin
        m_instr <= NOP; m_pc8 <= 0; m_valid <= 0;
      end else if (!StallD) begin
        m_instr <= mem_word(m_pc); m_pc8 <= m_pc + 8; m_valid <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_req", {31'b0, imem_req}, {31'b0, m_live});
    chk("m_addr", imem_addr, m_pc);
    chk("m_pcf", PCF, m_pc);
    chk("m_wait", {31'b0, ImemWaitF}, {31'b0, ~m_live | m_drain | ~imem_ready});
    chk("m_instr", InstrD, m_instr);
    chk("m_pc8", PCPlus8D, m_pc8);
    chk("m_valid", {31'b0, ValidD}, {31'b0, m_valid});
    chk("no_beef", {31'b0, InstrD == 32'hDEAD_BEEF}, 32'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    step(); step();
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_wait", {31'b0, ImemWaitF}, 32'h1);
    chk("rst_instr", InstrD, NOP);
    reset = 1'b0;
    #3 chk("first_req", {31'b0, imem_req}, 32'h0);
    // 1: straight line
    step(); chk("t1_pc0", PCF, 32'h0);
    step(); chk("t1_pc4", PCF, 32'h4);
    chk("t1_instr", InstrD, 32'h1000_0000);
    chk("t1_pc8", PCPlus8D, 32'h8);
    chk("t1_valid", {31'b0, ValidD}, 32'h1);
    step(); chk("t1_pc8f", PCF, 32'h8);
    // 2: wait states
    imem_ready = 0;
    step(); chk("t2_addr", imem_addr, 32'h8);
    chk("t2_wait", {31'b0, ImemWaitF}, 32'h1);
    chk("t2_valid", {31'b0, ValidD}, 32'h0);
    step(); chk("t2_addr2", imem_addr, 32'h8);
    imem_ready = 1;
    step(); chk("t2_instr", InstrD, 32'h1000_0008);
    chk("t2_pc", PCF, 32'hC);
    // 3: branch wins over writeback, ignores StallF
    BranchTakenE = 1; BranchTargetE = 32'h100; PCSrcWB = 1; ResultWB = 32'h200; StallF = 1;
    step(); chk("t3_pc", PCF, 32'h100);
    chk("t3_valid", {31'b0, ValidD}, 32'h0);
    BranchTakenE = 0; PCSrcWB = 0; StallF = 0;
    // 4: redirect during wait
    imem_ready = 0; PCSrcWB = 1; ResultWB = 32'h40;
    step(); chk("t4_hold", PCF, 32'h100);
    PCSrcWB = 0;
    step(); chk("t4_hold2", PCF, 32'h100);
    imem_ready = 1; bad = 1;
    step(); chk("t4_pc", PCF, 32'h40);
    chk("t4_valid", {31'b0, ValidD}, 32'h0);
    bad = 0;
    step(); chk("t4_instr", InstrD, 32'h1000_0040);
    // 5: stall/flush priority
    StallD = 1; FlushD = 1; StallF = 1;
    step(); chk("t5_flush", InstrD, NOP);
    chk("t5_fvalid", {31'b0, ValidD}, 32'h0);
    StallD = 0; FlushD = 0; StallF = 0;
    step(); chk("t5_load", InstrD, 32'h1000_0044);
    StallD = 1; StallF = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_i", InstrD, 32'h1000_0044);
      chk("t5_hold_p", PCPlus8D, 32'h4C);
      chk("t5_hold_v", {31'b0, ValidD}, 32'h1);
    end
    StallD = 0; StallF = 0;
    // 6: wrap, then reset mid-drain
    BranchTakenE = 1; BranchTargetE = 32'hFFFF_FFFC;
    step(); chk("t6_top", PCF, 32'hFFFF_FFFC);
    BranchTakenE = 0;
    step(); chk("t6_wrap", PCF, 32'h0);
    chk("t6_instr", InstrD, 32'h0FFF_FFFC);
    chk("t6_pc8", PCPlus8D, 32'h4);
    imem_ready = 0; BranchTakenE = 1; BranchTargetE = 32'h80;
    step(); BranchTakenE = 0;
    #2 reset = 1;
    #1 chk("t6_rpcf", PCF, 32'h0);
    chk("t6_rreq", {31'b0, imem_req}, 32'h0);
    chk("t6_rwait", {31'b0, ImemWaitF}, 32'h1);
    chk("t6_rinstr", InstrD, NOP);
    chk("t6_rpc8", PCPlus8D, 32'h0);
    chk("t6_rvalid", {31'b0, ValidD}, 32'h0);
    step(); reset = 0; imem_ready = 1;
    step(); step(); chk("t6_lost", PCF, 32'h4);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
